// File: rtl/ltpi_data_channel_fifo_requester.sv
//------------------------------------------------------------------------------
// ltpi_data_channel_fifo_requester
//
// Host-side requester in front of the data channel controller FIFO. It takes
// one host request at a time, pushes it into the FIFO request queue over the
// level handshake (req_wr_en / req_wr_ack), then pops the matching response
// (resp_rd_en / resp_rd_ack) and returns it to the host with a timeout flag.
// Responses that turn up after a timeout are counted in stale_cnt. They are
// drained from IDLE before any new request is accepted, which keeps later
// requests paired with their own responses.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   host_req_*          host request (valid/ready, ready is combinational)
//   host_resp_*         host response (valid/ready) with timeout status
//   req_wr_*, req_full  FIFO request-queue write side
//   resp_rd_*, resp_empty FIFO response-queue read side
//   busy                FSM is not in IDLE
//   stale_cnt           late responses still owed to timed-out requests
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a host request, or start draining a stale response
// WR_REQ    | req_wr_en held high, waiting for req_wr_ack
// WR_REL    | waiting for req_wr_ack to drop, then arm the response timer
// WAIT_RESP | waiting for a response in the FIFO, timer running
// RD_RESP   | resp_rd_en held high, waiting for resp_rd_ack
// RD_REL    | waiting for resp_rd_ack to drop, then present the response
// DRAIN     | popping a late response, which is then discarded
// DRAIN_REL | waiting for resp_rd_ack to drop, then retire one stale entry
// HOST_RESP | response held for the host until host_resp_ready
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ltpi_data_channel_fifo_requester #(
    parameter int REQ_WIDTH       = 32,
    parameter int RESP_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int STALE_CNT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_req_valid,
    input  logic [REQ_WIDTH-1:0]       host_req_data,
    output logic                       host_req_ready,
    output logic                       host_resp_valid,
    output logic [RESP_WIDTH-1:0]      host_resp_data,
    output logic                       host_resp_timeout,
    input  logic                       host_resp_ready,
    output logic                       req_wr_en,
    output logic [REQ_WIDTH-1:0]       req_wr_data,
    input  logic                       req_wr_ack,
    input  logic                       req_full,
    output logic                       resp_rd_en,
    input  logic [RESP_WIDTH-1:0]      resp_rd_data,
    input  logic                       resp_rd_ack,
    input  logic                       resp_empty,
    output logic                       busy,
    output logic [STALE_CNT_WIDTH-1:0] stale_cnt
);

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_REL, WAIT_RESP, RD_RESP, RD_REL, DRAIN, DRAIN_REL, HOST_RESP
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Down-counter: loaded on WAIT_RESP entry, terminal count at zero, so the
    // timeout fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_RESP.
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STALE_CNT_WIDTH-1:0] STALE_MAX = '1;

    state_t                     state, state_d;
    logic [CNT_W-1:0]           tmr, tmr_d;
    logic                       req_wr_en_d, resp_rd_en_d;
    logic [REQ_WIDTH-1:0]       req_wr_data_d;
    logic                       host_resp_valid_d, host_resp_timeout_d;
    logic [RESP_WIDTH-1:0]      host_resp_data_d;
    logic [STALE_CNT_WIDTH-1:0] stale_cnt_d;
    logic                       drain_pending;

    assign drain_pending  = (stale_cnt != '0) && !resp_empty;
    assign host_req_ready = (state == IDLE) && !req_full && !drain_pending;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            tmr               <= '0;
            req_wr_en         <= 1'b0;
            req_wr_data       <= '0;
            resp_rd_en        <= 1'b0;
            host_resp_valid   <= 1'b0;
            host_resp_data    <= '0;
            host_resp_timeout <= 1'b0;
            stale_cnt         <= '0;
        end else begin
            state             <= state_d;
            tmr               <= tmr_d;
            req_wr_en         <= req_wr_en_d;
            req_wr_data       <= req_wr_data_d;
            resp_rd_en        <= resp_rd_en_d;
            host_resp_valid   <= host_resp_valid_d;
            host_resp_data    <= host_resp_data_d;
            host_resp_timeout <= host_resp_timeout_d;
            stale_cnt         <= stale_cnt_d;
        end
    end

    always_comb begin
        state_d             = state;
        tmr_d               = tmr;
        req_wr_en_d         = req_wr_en;
        req_wr_data_d       = req_wr_data;
        resp_rd_en_d        = resp_rd_en;
        host_resp_valid_d   = host_resp_valid;
        host_resp_data_d    = host_resp_data;
        host_resp_timeout_d = host_resp_timeout;
        stale_cnt_d         = stale_cnt;

        case (state)
            IDLE: begin
                // A waiting late response is retired before any new request.
                if (drain_pending) begin
                    resp_rd_en_d = 1'b1;
                    state_d      = DRAIN;
                end else if (host_req_valid && host_req_ready) begin
                    req_wr_data_d = host_req_data;
                    req_wr_en_d   = 1'b1;
                    state_d       = WR_REQ;
                end
            end
            WR_REQ: begin
                if (req_wr_ack) begin
                    req_wr_en_d = 1'b0;
                    state_d     = WR_REL;
                end
            end
            WR_REL: begin
                if (!req_wr_ack) begin
                    tmr_d   = TMR_LOAD;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the terminal cycle still wins.
                if (!resp_empty) begin
                    resp_rd_en_d = 1'b1;
                    state_d      = RD_RESP;
                end else if (tmr == '0) begin
                    host_resp_valid_d   = 1'b1;
                    host_resp_timeout_d = 1'b1;
                    host_resp_data_d    = '0;
                    if (stale_cnt != STALE_MAX) begin
                        stale_cnt_d = stale_cnt + 1'b1;
                    end
                    state_d = HOST_RESP;
                end else begin
                    tmr_d = tmr - 1'b1;
                end
            end
            RD_RESP: begin
                if (resp_rd_ack) begin
                    host_resp_data_d = resp_rd_data;
                    resp_rd_en_d     = 1'b0;
                    state_d          = RD_REL;
                end
            end
            RD_REL: begin
                // Waiting for ack to drop keeps a second pop from starting early.
                if (!resp_rd_ack) begin
                    host_resp_valid_d   = 1'b1;
                    host_resp_timeout_d = 1'b0;
                    state_d             = HOST_RESP;
                end
            end
            DRAIN: begin
                if (resp_rd_ack) begin
                    resp_rd_en_d = 1'b0;
                    state_d      = DRAIN_REL;
                end
            end
            DRAIN_REL: begin
                if (!resp_rd_ack) begin
                    if (stale_cnt != '0) begin
                        stale_cnt_d = stale_cnt - 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            HOST_RESP: begin
                if (host_resp_ready) begin
                    host_resp_valid_d   = 1'b0;
                    host_resp_data_d    = '0;
                    host_resp_timeout_d = 1'b0;
                    state_d             = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ltpi_data_channel_fifo_requester.sv
`timescale 1ns/1ps

module tb_ltpi_data_channel_fifo_requester;

    localparam int RW  = 32;
    localparam int SW  = 32;
    localparam int TO  = 16;
    localparam int SCW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           host_req_valid;
    logic [RW-1:0]  host_req_data;
    logic           host_req_ready;
    logic           host_resp_valid;
    logic [SW-1:0]  host_resp_data;
    logic           host_resp_timeout;
    logic           host_resp_ready;
    logic           req_wr_en;
    logic [RW-1:0]  req_wr_data;
    logic           req_wr_ack;
    logic           req_full;
    logic           resp_rd_en;
    logic [SW-1:0]  resp_rd_data;
    logic           resp_rd_ack;
    logic           resp_empty;
    logic           busy;
    logic [SCW-1:0] stale_cnt;

    ltpi_data_channel_fifo_requester #(
        .REQ_WIDTH(RW), .RESP_WIDTH(SW), .TIMEOUT_CYCLES(TO), .STALE_CNT_WIDTH(SCW)
    ) dut (
        .clk(clk), .reset(reset),
        .host_req_valid(host_req_valid), .host_req_data(host_req_data),
        .host_req_ready(host_req_ready),
        .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data),
        .host_resp_timeout(host_resp_timeout), .host_resp_ready(host_resp_ready),
        .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_wr_ack(req_wr_ack),
        .req_full(req_full),
        .resp_rd_en(resp_rd_en), .resp_rd_data(resp_rd_data), .resp_rd_ack(resp_rd_ack),
        .resp_empty(resp_empty),
        .busy(busy), .stale_cnt(stale_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- FIFO model (updates inputs on the falling edge) ------
    logic [SW-1:0] rq[$];
    int            pend_cnt = -1;
    logic [SW-1:0] pend_data;
    int            plan_delay = -1;       // written by the stimulus only
    logic [SW-1:0] plan_data  = '0;
    int            late_issue = 0;        // written by the stimulus only
    logic [SW-1:0] late_word  = '0;
    int            late_done  = 0;
    int            rd_lat     = 0;
    int            wr_rise    = 0;
    int            rd_rise    = 0;
    logic [RW-1:0] last_wr_data = '0;
    logic [SW-1:0] last_pop     = '0;
    int            wait_entry_cyc = 0;
    logic          prev_wr_en = 1'b0;
    logic          prev_rd_en = 1'b0;

    initial begin
        req_wr_ack   = 1'b0;
        resp_rd_ack  = 1'b0;
        resp_rd_data = '0;
        resp_empty   = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                rq.delete();
                pend_cnt    = -1;
                rd_lat      = 0;
                req_wr_ack  = 1'b0;
                resp_rd_ack = 1'b0;
                resp_empty  = 1'b1;
                late_done   = late_issue;
                prev_wr_en  = 1'b0;
                prev_rd_en  = 1'b0;
            end else begin
                if (req_wr_en && !prev_wr_en) begin
                    wr_rise++;
                    last_wr_data = req_wr_data;
                    check("wr_start_while_full", req_full, 0);
                end
                if (resp_rd_en && !prev_rd_en) begin
                    rd_rise++;
                    check("rd_start_while_empty", resp_empty, 0);
                end
                if (req_wr_en || resp_rd_en)
                    check("wr_rd_exclusive", req_wr_en & resp_rd_en, 0);

                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        rq.push_back(pend_data);
                        pend_cnt = -1;
                    end
                end
                if (req_wr_en && !req_wr_ack) begin
                    req_wr_ack = 1'b1;
                    if (plan_delay > 0) begin
                        pend_cnt  = plan_delay;
                        pend_data = plan_data;
                    end
                end else if (!req_wr_en && req_wr_ack) begin
                    req_wr_ack     = 1'b0;
                    wait_entry_cyc = cyc + 1;
                end
                if (late_issue != late_done) begin
                    rq.push_back(late_word);
                    late_done = late_issue;
                end
                if (resp_rd_en && !resp_rd_ack) begin
                    rd_lat++;
                    if (rd_lat >= 3) begin
                        resp_rd_ack = 1'b1;
                        if (rq.size() > 0) resp_rd_data = rq.pop_front();
                        else               resp_rd_data = '0;
                        last_pop = resp_rd_data;
                        rd_lat   = 0;
                    end
                end else if (!resp_rd_en) begin
                    resp_rd_ack = 1'b0;
                    rd_lat      = 0;
                end
                resp_empty = (rq.size() == 0);
                prev_wr_en = req_wr_en;
                prev_rd_en = resp_rd_en;
            end
        end
    end

    // ---------------- host-side tasks (run at negedge + 1) ------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic host_send(input logic [RW-1:0] d, input int dly, input logic [SW-1:0] r);
        bit ok = 0;
        plan_delay     = dly;
        plan_data      = r;
        host_req_valid = 1'b1;
        host_req_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (host_req_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else begin
                step();
            end
        end
        host_req_valid = 1'b0;
        if (!ok) check("host_accept_timeout", 0, 1);
        step();
    endtask

    task automatic get_resp(output logic [SW-1:0] d, output logic t, output int vcyc, input int bp);
        bit seen = 0;
        host_resp_ready = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (host_resp_valid) seen = 1;
            else step();
        end
        d    = host_resp_data;
        t    = host_resp_timeout;
        vcyc = cyc;
        if (!seen) begin
            check("resp_valid_timeout", 0, 1);
        end else begin
            for (int i = 0; i < bp; i++) begin
                step();
                check("bp_valid_hold", host_resp_valid, 1);
                check("bp_data_hold", host_resp_data, d);
                check("bp_timeout_hold", host_resp_timeout, t);
            end
            host_resp_ready = 1'b1;
            step();
            host_resp_ready = 1'b0;
            check("idle_after_consume", busy, 0);
            check("valid_clear_after_consume", host_resp_valid, 0);
        end
    endtask

    task automatic drain_late(input logic [SW-1:0] w);
        bit saw_valid = 0;
        bit done = 0;
        int r0 = rd_rise;
        late_word = w;
        late_issue++;
        step();
        check("ready_low_during_drain", host_req_ready, 0);
        for (int i = 0; i < 60 && !done; i++) begin
            if (host_resp_valid) saw_valid = 1;
            if (stale_cnt == 0 && !busy) done = 1;
            else step();
        end
        check("drain_completes", done, 1);
        check("drain_no_host_valid", saw_valid, 0);
        check("drain_popped_word", last_pop, w);
        check("drain_one_pop", rd_rise - r0, 1);
        check("drain_stale_zero", stale_cnt, 0);
    endtask

    // ---------------- stimulus ---------------------------------------------
    logic [SW-1:0] rd;
    logic          rt;
    int            vc;
    int            w0, r0;
    bit            got;

    initial begin
        reset = 1'b1;
        host_req_valid  = 1'b0;
        host_req_data   = '0;
        host_resp_ready = 1'b0;
        req_full        = 1'b0;
        repeat (2) step();
        check("rst_req_wr_en", req_wr_en, 0);
        check("rst_req_wr_data", req_wr_data, 0);
        check("rst_resp_rd_en", resp_rd_en, 0);
        check("rst_resp_valid", host_resp_valid, 0);
        check("rst_resp_data", host_resp_data, 0);
        check("rst_resp_timeout", host_resp_timeout, 0);
        check("rst_stale", stale_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", host_req_ready, 1);
        reset = 1'b0;
        step();

        // Basic transaction
        w0 = wr_rise; r0 = rd_rise;
        host_send(32'hA5A50001, 10, 32'h5A5A0002);
        get_resp(rd, rt, vc, 0);
        check("basic_data", rd, 32'h5A5A0002);
        check("basic_timeout", rt, 0);
        check("basic_wr_pulses", wr_rise - w0, 1);
        check("basic_wr_data", last_wr_data, 32'hA5A50001);
        check("basic_rd_pulses", rd_rise - r0, 1);

        // Request queue full
        plan_delay = 4; plan_data = 32'h12340006;
        req_full = 1'b1;
        host_req_valid = 1'b1;
        host_req_data  = 32'h12340005;
        for (int i = 0; i < 20; i++) begin
            step();
            check("full_ready_low", host_req_ready, 0);
            check("full_wr_en_low", req_wr_en, 0);
        end
        req_full = 1'b0;
        step();
        host_req_valid = 1'b0;
        check("full_release_wr_en", req_wr_en, 1);
        check("full_release_wr_data", req_wr_data, 32'h12340005);
        get_resp(rd, rt, vc, 0);
        check("full_resp_data", rd, 32'h12340006);

        // Timeout
        host_send(32'h11112222, -1, '0);
        get_resp(rd, rt, vc, 0);
        check("to_latency", vc - wait_entry_cyc, TO);
        check("to_flag", rt, 1);
        check("to_data", rd, 0);
        check("to_stale", stale_cnt, 1);

        // Late-response drain, then a normal transaction
        drain_late(32'hDEAD0000);
        host_send(32'h00000003, 2, 32'h00000004);
        get_resp(rd, rt, vc, 0);
        check("post_drain_data", rd, 32'h00000004);
        check("post_drain_timeout", rt, 0);

        // Host back-pressure
        host_send(32'hB0B00007, 5, 32'hC0C00008);
        get_resp(rd, rt, vc, 5);
        check("bp_data", rd, 32'hC0C00008);

        // Randomised transactions against a spec-level expectation
        for (int n = 0; n < 12; n++) begin
            logic [RW-1:0] d = $urandom;
            logic [SW-1:0] r = $urandom;
            bit            tmo = ($urandom_range(0, 3) == 0);
            int            dly = tmo ? -1 : int'($urandom_range(1, 10));
            int            bp  = int'($urandom_range(0, 3));
            logic [SW-1:0] exp_d = tmo ? '0 : r;
            host_send(d, dly, r);
            check("rnd_wr_data", last_wr_data, d);
            get_resp(rd, rt, vc, bp);
            check("rnd_data", rd, exp_d);
            check("rnd_timeout", rt, tmo);
            check("rnd_stale", stale_cnt, tmo ? 1 : 0);
            if (tmo) begin
                check("rnd_to_latency", vc - wait_entry_cyc, TO);
                drain_late($urandom);
            end
        end

        // Reset while resp_rd_en is high, with a stale entry outstanding
        host_send(32'h00000077, -1, '0);
        get_resp(rd, rt, vc, 0);
        check("pre_rst_timeout", rt, 1);
        host_send(32'h00000099, 1, 32'h000055AA);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (resp_rd_en) got = 1;
            else step();
        end
        check("pre_rst_rd_en", got, 1);
        check("pre_rst_stale", stale_cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req_wr_en", req_wr_en, 0);
        check("mid_rst_req_wr_data", req_wr_data, 0);
        check("mid_rst_resp_rd_en", resp_rd_en, 0);
        check("mid_rst_resp_valid", host_resp_valid, 0);
        check("mid_rst_resp_data", host_resp_data, 0);
        check("mid_rst_resp_timeout", host_resp_timeout, 0);
        check("mid_rst_stale", stale_cnt, 0);
        check("mid_rst_busy", busy, 0);
        step();
        reset = 1'b0;
        step();

        // Recovery after reset
        host_send(32'h00001234, 3, 32'h00004321);
        get_resp(rd, rt, vc, 1);
        check("recover_data", rd, 32'h00004321);
        check("recover_timeout", rt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
